// File: rtl/systolic_stream_ctrl_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
// Optional PERF_CNT_EN build macro adds tile/stall counters to the top.
package systolic_stream_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, HOLD} state_t;

   typedef struct packed {
      logic vld;
      int   idx;
   } lane_off_t;

   localparam int SIZE_DEF       = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int STREAM_LEN     = 2*SIZE_DEF - 1;
   localparam int CNT_W          = $clog2(STREAM_LEN + SIZE_DEF + 4 + 1);

   function automatic int stream_len(input int size);
      return 2*size - 1;
   endfunction

   function automatic int cnt_width(input int size, input int drain);
      return $clog2(stream_len(size) + drain + 1);
   endfunction

   // Lane m at step t carries element t-m of its row/column, if that exists.
   function automatic lane_off_t lane_offset(input int t, input int m, input int size);
      lane_off_t r;
      int d;
      d     = t - m;
      r.vld = (d >= 0) && (d < size);
      r.idx = d;
      return r;
   endfunction

endpackage

// File: rtl/systolic_stream_ctrl_tile_skew_mux.sv
// Picks the diagonally skewed vector out of a buffered tile for step t.
// Buffers are stored lane-major, so the same mux serves A rows and B columns.
module tile_skew_mux
   import systolic_stream_ctrl_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int DATA_WIDTH = 8,
   parameter int STEP_W     = 5
) (
   input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] tile_buf,
   input  logic [STEP_W-1:0]                         t,
   output logic [SIZE-1:0][DATA_WIDTH-1:0]           vec
);

   lane_off_t off;

   always_comb begin
      vec = '0;
      off = '0;
      for (int m = 0; m < SIZE; m++) begin
         off = lane_offset(int'(t), m, SIZE);
         for (int k = 0; k < SIZE; k++) begin
            if (off.vld && (off.idx == k)) vec[m] = tile_buf[m][k];
         end
      end
   end

endmodule

// File: rtl/systolic_stream_ctrl.sv
// Tile sequencer: buffers A/B, clears and streams a systolic array, captures C.
// Build macro PERF_CNT_EN adds perf_tiles / perf_stall counters.
module systolic_stream_ctrl
   import systolic_stream_ctrl_pkg::*;
#(
   parameter int SIZE         = SIZE_DEF,
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int DRAIN_CYCLES = SIZE + 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   ld_valid,
   output logic                                   ld_ready,
   input  logic                                   ld_sel,
   input  logic [(SIZE>1 ? $clog2(SIZE) : 1)-1:0] ld_idx,
   input  logic [SIZE*DATA_WIDTH-1:0]             ld_data,
   input  logic                                   go,
   output logic                                   busy,
   output logic                                   arr_rst_n,
   output logic                                   arr_start,
   output logic [SIZE*DATA_WIDTH-1:0]             arr_A,
   output logic [SIZE*DATA_WIDTH-1:0]             arr_B,
   input  logic [SIZE*SIZE*2*DATA_WIDTH-1:0]      arr_C,
   output logic                                   res_valid,
   input  logic                                   res_ready,
   output logic [SIZE*SIZE*2*DATA_WIDTH-1:0]      res_C
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]                            perf_tiles,
   output logic [31:0]                            perf_stall
`endif
);

   localparam int STEPS = stream_len(SIZE);
   localparam int CW    = cnt_width(SIZE, DRAIN_CYCLES);

   typedef logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] tile_t;
   typedef logic [SIZE-1:0][DATA_WIDTH-1:0]           vec_t;

   state_t        state;
   logic [CW-1:0] cnt;
   tile_t         a_buf;
   tile_t         b_buf;   // transposed: b_buf[col][row]
   vec_t          skew_a;
   vec_t          skew_b;
   logic          idx_ok;

   assign idx_ok   = int'(ld_idx) < SIZE;
   assign ld_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   tile_skew_mux #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .STEP_W(CW)) u_skew_a (
      .tile_buf(a_buf), .t(cnt), .vec(skew_a)
   );

   tile_skew_mux #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .STEP_W(CW)) u_skew_b (
      .tile_buf(b_buf), .t(cnt), .vec(skew_b)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         a_buf     <= '0;
         b_buf     <= '0;
         arr_rst_n <= 1'b1;
         arr_start <= 1'b0;
         arr_A     <= '0;
         arr_B     <= '0;
         res_valid <= 1'b0;
         res_C     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_valid && idx_ok) begin
                  if (ld_sel) b_buf[ld_idx] <= ld_data;
                  else        a_buf[ld_idx] <= ld_data;
               end
               if (go) state <= CLEAR;
            end
            CLEAR: begin
               arr_rst_n <= 1'b0;
               cnt       <= '0;
               state     <= STREAM;
            end
            // Vector for step cnt appears on the array ports one cycle later.
            STREAM: begin
               arr_rst_n <= 1'b1;
               arr_start <= 1'b1;
               arr_A     <= skew_a;
               arr_B     <= skew_b;
               if (cnt == CW'(STEPS-1)) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               arr_start <= 1'b0;
               arr_A     <= '0;
               arr_B     <= '0;
               if (cnt == CW'(DRAIN_CYCLES-1)) begin
                  res_C     <= arr_C;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_tiles <= '0;
         perf_stall <= '0;
      end else begin
         if (res_valid && res_ready)  perf_tiles <= perf_tiles + 32'd1;
         if (res_valid && !res_ready) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_stream_ctrl.sv
// Directed bench: SIZE=2 and SIZE=8 sequencers driving a behavioural systolic array.
// Optional PERF_CNT_EN checks follow the RTL build macro.
module tb_systolic_stream_ctrl;

   localparam int D2 = 6;
   localparam int D8 = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst2, rst8;
   logic          ld_valid2, ld_ready2, ld_sel2, go2, busy2, arr_rst_n2, arr_start2, res_valid2, res_ready2;
   logic [0:0]    ld_idx2;
   logic [15:0]   ld_data2, arr_A2, arr_B2;
   logic [63:0]   arr_C2, res_C2;
   logic          ld_valid8, ld_ready8, ld_sel8, go8, busy8, arr_rst_n8, arr_start8, res_valid8, res_ready8;
   logic [2:0]    ld_idx8;
   logic [63:0]   ld_data8, arr_A8, arr_B8;
   logic [1023:0] arr_C8, res_C8;
`ifdef PERF_CNT_EN
   logic [31:0]   perf_tiles2, perf_stall2, perf_tiles8, perf_stall8;
`endif

   systolic_stream_ctrl #(.SIZE(2), .DATA_WIDTH(8), .DRAIN_CYCLES(D2)) u2 (
      .clk(clk), .rst(rst2), .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_sel(ld_sel2),
      .ld_idx(ld_idx2), .ld_data(ld_data2), .go(go2), .busy(busy2), .arr_rst_n(arr_rst_n2),
      .arr_start(arr_start2), .arr_A(arr_A2), .arr_B(arr_B2), .arr_C(arr_C2),
      .res_valid(res_valid2), .res_ready(res_ready2), .res_C(res_C2)
`ifdef PERF_CNT_EN
      , .perf_tiles(perf_tiles2), .perf_stall(perf_stall2)
`endif
   );

   systolic_stream_ctrl #(.SIZE(8), .DATA_WIDTH(8), .DRAIN_CYCLES(D8)) u8 (
      .clk(clk), .rst(rst8), .ld_valid(ld_valid8), .ld_ready(ld_ready8), .ld_sel(ld_sel8),
      .ld_idx(ld_idx8), .ld_data(ld_data8), .go(go8), .busy(busy8), .arr_rst_n(arr_rst_n8),
      .arr_start(arr_start8), .arr_A(arr_A8), .arr_B(arr_B8), .arr_C(arr_C8),
      .res_valid(res_valid8), .res_ready(res_ready8), .res_C(res_C8)
`ifdef PERF_CNT_EN
      , .perf_tiles(perf_tiles8), .perf_stall(perf_stall8)
`endif
   );

   // Behavioural output-stationary array: A flows right, B flows down, one hop per cycle.
   int acc [2][8][8];
   int ar  [2][8][8];
   int br  [2][8][8];

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         int n;
         logic rn;
         logic [63:0] va, vb;
         n  = (u == 0) ? 2 : 8;
         rn = (u == 0) ? arr_rst_n2 : arr_rst_n8;
         va = (u == 0) ? {48'b0, arr_A2} : arr_A8;
         vb = (u == 0) ? {48'b0, arr_B2} : arr_B8;
         for (int i = n-1; i >= 0; i--) begin
            for (int j = n-1; j >= 0; j--) begin
               int a_in, b_in;
               if (!rn) begin
                  acc[u][i][j] = 0; ar[u][i][j] = 0; br[u][i][j] = 0;
               end else begin
                  a_in = (j == 0) ? int'($signed(va[i*8 +: 8])) : ar[u][i][j-1];
                  b_in = (i == 0) ? int'($signed(vb[j*8 +: 8])) : br[u][i-1][j];
                  acc[u][i][j] = acc[u][i][j] + a_in * b_in;
                  ar[u][i][j]  = a_in;
                  br[u][i][j]  = b_in;
               end
            end
         end
      end
   end

   always_comb begin
      arr_C2 = '0;
      arr_C8 = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) arr_C2[(i*2+j)*16 +: 16] = 16'(acc[0][i][j]);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) arr_C8[(i*8+j)*16 +: 16] = 16'(acc[1][i][j]);
   end

   typedef struct { logic [15:0] a; logic [15:0] b; } step_t;
   typedef struct { string name; int i; int j; logic [15:0] exp; } elem_t;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load2(input logic sel, input logic idx, input logic [15:0] d);
      ld_valid2 = 1'b1; ld_sel2 = sel; ld_idx2 = idx; ld_data2 = d;
      tick();
      ld_valid2 = 1'b0;
   endtask

   task automatic load8(input logic sel, input logic [2:0] idx, input logic [63:0] d);
      ld_valid8 = 1'b1; ld_sel8 = sel; ld_idx8 = idx; ld_data8 = d;
      tick();
      ld_valid8 = 1'b0;
   endtask

   task automatic start2(output int lat);
      go2 = 1'b1;
      tick();
      go2 = 1'b0;
      lat = 1;
      while (!res_valid2 && lat < 300) begin tick(); lat++; end
   endtask

   task automatic finish2(input int stall);
      repeat (stall) tick();
      res_ready2 = 1'b1;
      tick();
      res_ready2 = 1'b0;
      chk("s2 handshake res_valid", res_valid2, 0);
   endtask

   task automatic start8(output int lat);
      go8 = 1'b1;
      tick();
      go8 = 1'b0;
      lat = 1;
      while (!res_valid8 && lat < 300) begin tick(); lat++; end
   endtask

   step_t          st2 [3];
   elem_t          e2a [4];
   elem_t          e2b [4];
   elem_t          e8  [6];
   logic [1023:0]  exp8, snap;
   logic [63:0]    d8;
   int             cyc, lat;
   logic           seen;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      st2[0] = '{16'h0001, 16'h0005};
      st2[1] = '{16'h0302, 16'h0607};
      st2[2] = '{16'h0400, 16'h0800};
      e2a[0] = '{"s2 C00", 0, 0, 16'd19};
      e2a[1] = '{"s2 C01", 0, 1, 16'd22};
      e2a[2] = '{"s2 C10", 1, 0, 16'd43};
      e2a[3] = '{"s2 C11", 1, 1, 16'd50};
      e2b[0] = '{"s2b C00", 0, 0, 16'h0002};
      e2b[1] = '{"s2b C01", 0, 1, 16'hFFFE};
      e2b[2] = '{"s2b C10", 1, 0, 16'h000C};
      e2b[3] = '{"s2b C11", 1, 1, 16'h000F};
      e8[0]  = '{"s8 C23", 2, 3, 16'hFFFB};
      e8[1]  = '{"s8 C00", 0, 0, 16'h0000};
      e8[2]  = '{"s8 C77", 7, 7, 16'hFFF2};
      e8[3]  = '{"s8 C70", 7, 0, 16'hFFF9};
      e8[4]  = '{"s8 C07", 0, 7, 16'hFFF9};
      e8[5]  = '{"s8 C52", 5, 2, 16'hFFF9};

      rst2 = 1'b0; rst8 = 1'b0;
      ld_valid2 = 0; ld_sel2 = 0; ld_idx2 = '0; ld_data2 = '0; go2 = 0; res_ready2 = 0;
      ld_valid8 = 0; ld_sel8 = 0; ld_idx8 = '0; ld_data8 = '0; go8 = 0; res_ready8 = 0;
      repeat (2) tick();

      chk("rst busy", busy2, 0);
      chk("rst arr_rst_n", arr_rst_n2, 1);
      chk("rst arr_start", arr_start8, 0);
      chk("rst arr_A", arr_A8, 0);
      chk("rst arr_B", arr_B8, 0);
      chk("rst res_valid", res_valid8, 0);
      chk("rst res_C", res_C2, 0);
      rst2 = 1'b1; rst8 = 1'b1;
      tick();
      chk("idle ld_ready", ld_ready2, 1);

      // SIZE=2 product, last B column written in the same cycle as go
      load2(0, 0, 16'h0201);
      load2(0, 1, 16'h0403);
      load2(1, 0, 16'h0705);
      ld_valid2 = 1; ld_sel2 = 1; ld_idx2 = 1; ld_data2 = 16'h0806; go2 = 1;
      tick();
      ld_valid2 = 0; go2 = 0; cyc = 1;
      chk("clear busy", busy2, 1);
      chk("clear ld_ready", ld_ready2, 0);
      chk("clear arr_rst_n", arr_rst_n2, 1);
      tick(); cyc++;
      chk("array reset pulse", arr_rst_n2, 0);
      chk("array start pre", arr_start2, 0);
      for (int s = 0; s < 3; s++) begin
         tick(); cyc++;
         chk($sformatf("s2 step%0d arr_A", s), arr_A2, st2[s].a);
         chk($sformatf("s2 step%0d arr_B", s), arr_B2, st2[s].b);
         chk($sformatf("s2 step%0d arr_start", s), arr_start2, 1);
      end
      while (!res_valid2 && cyc < 300) begin tick(); cyc++; end
      chk("s2 latency", cyc, 5 + D2);
      chk("hold arr_start", arr_start2, 0);
      chk("hold arr_A", arr_A2, 0);
      for (int e = 0; e < 4; e++)
         chk(e2a[e].name, res_C2[(e2a[e].i*2 + e2a[e].j)*16 +: 16], e2a[e].exp);
      finish2(0);
      chk("s2 back to idle", busy2, 0);

      // SIZE=8: A = -I, B[i][j] = i+j
      for (int r = 0; r < 8; r++) begin
         d8 = '0; d8[r*8 +: 8] = 8'hFF;
         load8(0, 3'(r), d8);
      end
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(k + c);
         load8(1, 3'(c), d8);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) exp8[(i*8+j)*16 +: 16] = 16'(-(i + j));
      start8(lat);
      chk("s8 latency", lat, 1 + 1 + 15 + D8);
      for (int e = 0; e < 6; e++)
         chk(e8[e].name, res_C8[(e8[e].i*8 + e8[e].j)*16 +: 16], e8[e].exp);
      chk("s8 full tile", res_C8 === exp8, 1);

      // Backpressure: result held, loads blocked, go ignored
      snap = res_C8;
      for (int k = 0; k < 10; k++) begin
         go8 = k[0];
         tick();
         chk("bp res_valid", res_valid8, 1);
         chk("bp res_C stable", res_C8 === snap, 1);
         chk("bp ld_ready", ld_ready8, 0);
      end
      go8 = 0; res_ready8 = 1;
      tick();
      res_ready8 = 0;
      chk("bp handshake res_valid", res_valid8, 0);
      chk("bp handshake busy", busy8, 0);
      tick();
      chk("bp go not latched", busy8, 0);

      // Load attempt while streaming must not touch the buffers
      go8 = 1; tick(); go8 = 0; lat = 1;
      while (!arr_start8 && lat < 50) begin tick(); lat++; end
      ld_valid8 = 1; ld_sel8 = 0; ld_idx8 = 3'd2; ld_data8 = '1;
      repeat (3) begin
         tick(); lat++;
         chk("stream ld_ready", ld_ready8, 0);
      end
      ld_valid8 = 0;
      while (!res_valid8 && lat < 300) begin tick(); lat++; end
      chk("s8 rerun latency", lat, 29);
      chk("s8 rerun tile", res_C8 === exp8, 1);
      res_ready8 = 1; tick(); res_ready8 = 0;

      // Reset in DRAIN discards the tile
      go2 = 1; tick(); go2 = 0; cyc = 1;
      repeat (6) begin tick(); cyc++; end
      chk("pre-reset busy", busy2, 1);
      rst2 = 1'b0;
      #1;
      chk("mid rst busy", busy2, 0);
      chk("mid rst arr_rst_n", arr_rst_n2, 1);
      chk("mid rst arr_start", arr_start2, 0);
      chk("mid rst arr_A", arr_A2, 0);
      chk("mid rst arr_B", arr_B2, 0);
      chk("mid rst res_valid", res_valid2, 0);
      chk("mid rst res_C", res_C2, 0);
      tick();
      rst2 = 1'b1;
      seen = 0;
      repeat (20) begin tick(); if (res_valid2) seen = 1; end
      chk("no result after reset", seen, 0);

      // Fresh tile, then two recomputes (second one stalls 4 cycles)
      load2(0, 0, 16'h0002);
      load2(0, 1, 16'h0300);
      load2(1, 0, 16'h0401);
      load2(1, 1, 16'h05FF);
      for (int t = 0; t < 3; t++) begin
         start2(lat);
         chk("s2b latency", lat, 5 + D2);
         for (int e = 0; e < 4; e++)
            chk(e2b[e].name, res_C2[(e2b[e].i*2 + e2b[e].j)*16 +: 16], e2b[e].exp);
         finish2(t == 1 ? 4 : 0);
      end
`ifdef PERF_CNT_EN
      chk("perf_tiles", perf_tiles2, 3);
      chk("perf_stall", perf_stall2, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
